ahblite_slave_mux_n: RTL and testbench
======================================

Name: ahblite_slave_mux_n

Overview:
Parametrised AHB-Lite data-phase response multiplexer for NPORT slaves, with an integrated default slave.
- Registers the address-phase slave select.
- Routes the selected slave's HREADYOUT/HRESP/HRDATA back to the master.
- Produces a two-cycle AHB ERROR response for any active transfer that selects no slave or more than one slave.
- Keeps a saturating decode-error counter for software/debug.
- Sits between the address decoder and the master-side HREADY/HRESP/HRDATA in the AHB-Lite matrix.

Parameters:
NPORT, 7, number of slave ports (1..32)
DW, 32, data width of HRDATA (32 or 64)
CW, 8, width of decode-error counter

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
HREADY  input  1  bus HREADY (transfer-complete qualifier)
HTRANS  input  2  address-phase transfer type; bit1=1 means NONSEQ/SEQ
HSEL_VEC  input  NPORT  address-phase slave selects, bit i = port i
P_HREADYOUT  input  NPORT  per-port HREADYOUT, bit i = port i
P_HRESP  input  NPORT  per-port HRESP
P_HRDATA  input  NPORT*DW  per-port read data, port i at [i*DW +: DW]
ERR_CLR  input  1  synchronous clear of ERR_CNT
HREADYOUT  output  1  muxed ready to master
HRESP  output  1  muxed response to master (1=ERROR)
HRDATA  output  DW  muxed read data
ERR_CNT  output  CW  saturating count of decode errors

Clock/reset: one clock, HCLK; reset HRESETn, asynchronous, active-low.

Behaviour:
- Reset values:
  - sel_q = 0, state = IDLE, ERR_CNT = 0.
  - Outputs therefore HREADYOUT=1, HRESP=0, HRDATA=0.
- Address-phase capture, only when HREADY=1:
  - onehot = exactly one bit of HSEL_VEC set.
  - sel_q <= onehot ? HSEL_VEC : 0.
  - dec_err = HTRANS[1] & ~onehot.
  - HTRANS IDLE/BUSY (bit1=0) with no or multiple HSEL: no error; sel_q=0.
  - HREADY=0: sel_q and state hold.
- Data-phase mux (combinational from sel_q):
  - sel_q onehot at port i: HREADYOUT=P_HREADYOUT[i], HRESP=P_HRESP[i], HRDATA=P_HRDATA[i*DW +: DW].
  - sel_q=0 and state IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
- Default-slave FSM (states IDLE, ERR1, ERR2):
  - IDLE -> ERR1 when HREADY & dec_err.
  - ERR1: HREADYOUT=0, HRESP=1, HRDATA=0; unconditional -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, HRDATA=0.
    - Since HREADY=1 in ERR2, a new address phase is captured.
    - -> ERR1 if dec_err, else -> IDLE.
  - While state != IDLE, FSM outputs override the slave mux. sel_q is 0 then by construction.
  - Back-to-back decode errors give the pattern ERR1, ERR2, ERR1, ERR2…
- Latency:
  - Slave response appears one cycle after the accepted address phase; zero added wait states.
  - Decode error costs exactly two data-phase cycles.
- ERR_CNT:
  - Increments on each IDLE/ERR2 -> ERR1 transition.
  - Saturates at 2^CW-1 with no wrap.
  - ERR_CLR=1 clears it.
  - ERR_CLR and increment in the same cycle -> ERR_CNT=1.
- Reset mid-operation (e.g. in ERR1) returns immediately to the reset values; no pending error is retained.
- NPORT=1: onehot = HSEL_VEC[0].

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - HRESP_OKAY/HRESP_ERROR.
  - Default-slave state enum.
- Sub-module ahblite_default_slave:
  - Holds the FSM and ERR_CNT.
  - Inputs: HCLK, HRESETn, HREADY, dec_err, ERR_CLR.
  - Outputs: active, ds_hreadyout, ds_hresp, ERR_CNT.
- Top level holds sel_q, the onehot check and the output mux.

Test Plan:
- Reset released, no traffic -> HREADYOUT=1, HRESP=0, HRDATA=0, ERR_CNT=0.
- NONSEQ with HSEL_VEC=7'b0000100, P_HRDATA port2=32'hA5A5_0002, P2 HREADYOUT low 2 cycles -> HREADYOUT low 2 cycles then 1, with HRDATA=32'hA5A5_0002 on the ready cycle.
- NONSEQ with HSEL_VEC=0 -> next cycle HREADYOUT=0/HRESP=1, following cycle HREADYOUT=1/HRESP=1, then IDLE; ERR_CNT=1.
- NONSEQ with HSEL_VEC=7'b0000011 (multi-hot) followed immediately by another NONSEQ with HSEL=0 -> ERR1, ERR2, ERR1, ERR2; ERR_CNT=2; no port data leaked.
- IDLE HTRANS with HSEL_VEC=0 -> no error, HREADYOUT=1, HRESP=0.
- CW=2, five decode errors -> ERR_CNT saturates at 3; ERR_CLR coincident with a new error -> ERR_CNT=1. Assert HRESETn low during ERR1 -> outputs return to reset values at once.

Source files
------------

// File: rtl/ahblite_slave_mux_n_pkg.sv
// ahb_lite_pkg: shared AHB-Lite encodings and the default-slave state type.
//   HTRANS_*  : address-phase transfer type encodings
//   HRESP_*   : data-phase response encodings
//   ds_state_e: default-slave FSM states (IDLE, ERR1, ERR2)
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahblite_slave_mux_n_if.sv
// ahblite_slave_mux_n_if: bus bundle between the address decoder / slaves and
// the data-phase response multiplexer.
//   master modport: the bus side (drives HREADY, HTRANS, HSEL_VEC, per-port
//                   responses and ERR_CLR; observes the muxed response)
//   slave modport : the multiplexer side (the reverse directions)
interface ahblite_slave_mux_n_if #(
  parameter int NPORT = 7,
  parameter int DW    = 32,
  parameter int CW    = 8
);
  logic                HREADY;
  logic [1:0]          HTRANS;
  logic [NPORT-1:0]    HSEL_VEC;
  logic [NPORT-1:0]    P_HREADYOUT;
  logic [NPORT-1:0]    P_HRESP;
  logic [NPORT*DW-1:0] P_HRDATA;
  logic                ERR_CLR;
  logic                HREADYOUT;
  logic                HRESP;
  logic [DW-1:0]       HRDATA;
  logic [CW-1:0]       ERR_CNT;

  modport master (
    output HREADY, HTRANS, HSEL_VEC, P_HREADYOUT, P_HRESP, P_HRDATA, ERR_CLR,
    input  HREADYOUT, HRESP, HRDATA, ERR_CNT
  );

  modport slave (
    input  HREADY, HTRANS, HSEL_VEC, P_HREADYOUT, P_HRESP, P_HRDATA, ERR_CLR,
    output HREADYOUT, HRESP, HRDATA, ERR_CNT
  );
endinterface

// File: rtl/ahblite_slave_mux_n_default_slave.sv
// ahblite_default_slave: two-cycle AHB ERROR responder plus saturating
// decode-error counter.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   HREADY        : bus transfer-complete qualifier
//   dec_err       : current address phase selects no slave or several
//   ERR_CLR       : synchronous clear of ERR_CNT
//   active        : FSM owns the data phase (overrides the slave mux)
//   ds_hreadyout  : default-slave HREADYOUT
//   ds_hresp      : default-slave HRESP
//   ERR_CNT       : saturating decode-error count
module ahblite_default_slave
  import ahb_lite_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HREADY,
  input  logic          dec_err,
  input  logic          ERR_CLR,
  output logic          active,
  output logic          ds_hreadyout,
  output logic          ds_hresp,
  output logic [CW-1:0] ERR_CNT
);

  ds_state_e     state_q, state_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          err_inc;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= DS_IDLE;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (HREADY && dec_err) state_d = DS_ERR1;
      // ERR1 drives HREADYOUT low, so the bus cannot start anything here.
      DS_ERR1: state_d = DS_ERR2;
      // ERR2 completes the error; a new address phase is sampled now.
      DS_ERR2: if (HREADY) state_d = dec_err ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // Counter steps on every entry into ERR1; a clear in the same cycle
  // still records the new error.
  always_comb begin
    err_inc   = (state_d == DS_ERR1) && (state_q != DS_ERR1);
    err_cnt_d = err_cnt_q;
    if (ERR_CLR)
      err_cnt_d = err_inc ? CW'(1) : '0;
    else if (err_inc && (err_cnt_q != {CW{1'b1}}))
      err_cnt_d = err_cnt_q + CW'(1);
  end

  always_comb begin
    active       = (state_q != DS_IDLE);
    ds_hreadyout = (state_q != DS_ERR1);
    ds_hresp     = active ? HRESP_ERROR : HRESP_OKAY;
  end

  assign ERR_CNT = err_cnt_q;

endmodule

// File: rtl/ahblite_slave_mux_n.sv
// ahblite_slave_mux_n: AHB-Lite data-phase response multiplexer for NPORT
// slaves with an integrated default slave.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus (slave)   : HREADY/HTRANS/HSEL_VEC address phase in, per-port
//                   P_HREADYOUT/P_HRESP/P_HRDATA in, ERR_CLR in;
//                   muxed HREADYOUT/HRESP/HRDATA and ERR_CNT out
module ahblite_slave_mux_n
  import ahb_lite_pkg::*;
#(
  parameter int NPORT = 7,
  parameter int DW    = 32,
  parameter int CW    = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahblite_slave_mux_n_if.slave  bus
);

  logic [NPORT-1:0] sel_q, sel_d;
  logic             trans_active;
  logic             onehot;
  logic             dec_err;
  logic             ds_active;
  logic             ds_hreadyout;
  logic             ds_hresp;
  logic             mux_hreadyout;
  logic             mux_hresp;
  logic [DW-1:0]    mux_hrdata;
  logic [DW-1:0]    port_data [NPORT];

  always_comb begin
    trans_active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    onehot  = (bus.HSEL_VEC != '0) &&
              ((bus.HSEL_VEC & (bus.HSEL_VEC - NPORT'(1))) == '0);
    dec_err = trans_active && !onehot;
    sel_d   = sel_q;
    if (bus.HREADY)
      sel_d = onehot ? bus.HSEL_VEC : '0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sel_q <= '0;
    else          sel_q <= sel_d;
  end

  // AND-OR read-data mux; sel_q is one-hot or zero, so at most one term is live.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign port_data[gi] = sel_q[gi] ? bus.P_HRDATA[gi*DW +: DW] : '0;
  end

  always_comb begin
    mux_hrdata = '0;
    for (int i = 0; i < NPORT; i++)
      mux_hrdata = mux_hrdata | port_data[i];
    mux_hreadyout = (sel_q == '0) ? 1'b1 : |(sel_q & bus.P_HREADYOUT);
    mux_hresp     = |(sel_q & bus.P_HRESP);
  end

  ahblite_default_slave #(.CW(CW)) u_default_slave (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HREADY       (bus.HREADY),
    .dec_err      (dec_err),
    .ERR_CLR      (bus.ERR_CLR),
    .active       (ds_active),
    .ds_hreadyout (ds_hreadyout),
    .ds_hresp     (ds_hresp),
    .ERR_CNT      (bus.ERR_CNT)
  );

  always_comb begin
    if (ds_active) begin
      bus.HREADYOUT = ds_hreadyout;
      bus.HRESP     = ds_hresp;
      bus.HRDATA    = '0;
    end else begin
      bus.HREADYOUT = mux_hreadyout;
      bus.HRESP     = mux_hresp;
      bus.HRDATA    = mux_hrdata;
    end
  end

endmodule

// File: tb/tb_ahblite_slave_mux_n.sv
// Testbench for ahblite_slave_mux_n (NPORT=7, DW=32, CW=2). HREADY is looped
// back from HREADYOUT as in a single-master AHB-Lite system.
module tb_ahblite_slave_mux_n;

  localparam int NPORT = 7;
  localparam int DW    = 32;
  localparam int CW    = 2;

  typedef struct {
    int              waits;
    logic            resp;
    logic [DW-1:0]   data;
    logic [CW-1:0]   cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  ahblite_slave_mux_n_if #(.NPORT(NPORT), .DW(DW), .CW(CW)) bus ();

  ahblite_slave_mux_n #(.NPORT(NPORT), .DW(DW), .CW(CW)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  assign bus.HREADY = bus.HREADYOUT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t          exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          mon_en   = 1'b1;
  logic [CW-1:0] mon_cnt  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle either completes/extends a data phase against the
  // scoreboard, or confirms the idle response.
  logic dp_now = 1'b0;
  int   waits  = 0;
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      dp_now = 1'b0;
      waits  = 0;
    end else begin
      if (dp_now) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dphase", 1, 0);
          dp_now = 1'b0;
        end else if (!bus.HREADYOUT) begin
          waits++;
          chk("wait_resp", bus.HRESP, exp_q[0].resp);
          if (waits > 16) begin
            chk("dphase_timeout", waits, exp_q[0].waits);
            void'(exp_q.pop_front());
            dp_now = 1'b0;
          end
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("waits", waits, e.waits);
          chk("hresp", bus.HRESP, e.resp);
          chk("hrdata", bus.HRDATA, e.data);
          chk("err_cnt", bus.ERR_CNT, e.cnt);
          $display("txn done: waits=%0d hresp=%0d hrdata=0x%08h err_cnt=%0d",
                   waits, bus.HRESP, bus.HRDATA, bus.ERR_CNT);
          mon_cnt = e.cnt;
          dp_now  = 1'b0;
        end
      end else begin
        chk("idle_hreadyout", bus.HREADYOUT, 1);
        chk("idle_hresp", bus.HRESP, 0);
        chk("idle_hrdata", bus.HRDATA, 0);
        chk("idle_err_cnt", bus.ERR_CNT, mon_cnt);
      end
      if (bus.HREADY) begin
        dp_now = bus.HTRANS[1];
        waits  = 0;
      end
    end
  end

  task automatic expect_tx(input int w, input logic r, input logic [DW-1:0] d,
                           input logic [CW-1:0] c);
    exp_t e;
    e.waits = w; e.resp = r; e.data = d; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Present an address phase and return just after the edge that accepts it.
  task automatic issue(input logic [1:0] tr, input logic [NPORT-1:0] hs, input logic clr);
    bit ok;
    ok = 1'b0;
    bus.HTRANS   = tr;
    bus.HSEL_VEC = hs;
    bus.ERR_CLR  = clr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.HREADY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.ERR_CLR = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.HTRANS   = 2'b00;
    bus.HSEL_VEC = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.HTRANS      = 2'b00;
    bus.HSEL_VEC    = '0;
    bus.ERR_CLR     = 1'b0;
    bus.P_HREADYOUT = '1;
    bus.P_HRESP     = '0;
    for (int i = 0; i < NPORT; i++)
      bus.P_HRDATA[i*DW +: DW] = 32'hA5A5_0000 | i;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // Port 2 read with two slave wait states.
    bus.P_HREADYOUT[2] = 1'b0;
    expect_tx(2, 1'b0, 32'hA5A5_0002, 2'd0);
    issue(2'b10, 7'b0000100, 1'b0);
    bus.HTRANS = 2'b00; bus.HSEL_VEC = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.P_HREADYOUT[2] = 1'b1;
    idle_cycles(2);

    // Pipelined zero-wait reads from ports 6 then 0.
    expect_tx(0, 1'b0, 32'hA5A5_0006, 2'd0);
    expect_tx(0, 1'b0, 32'hA5A5_0000, 2'd0);
    issue(2'b10, 7'b1000000, 1'b0);
    issue(2'b11, 7'b0000001, 1'b0);
    idle_cycles(2);

    // Slave-generated ERROR passes through the mux.
    bus.P_HRESP[3] = 1'b1;
    expect_tx(0, 1'b1, 32'hA5A5_0003, 2'd0);
    issue(2'b10, 7'b0001000, 1'b0);
    idle_cycles(1);
    bus.P_HRESP[3] = 1'b0;
    idle_cycles(1);

    // No slave selected: two-cycle error.
    expect_tx(1, 1'b1, 32'h0, 2'd1);
    issue(2'b10, 7'b0000000, 1'b0);
    idle_cycles(3);

    // Multi-hot then no-select, back to back; no port data may leak.
    expect_tx(1, 1'b1, 32'h0, 2'd2);
    expect_tx(1, 1'b1, 32'h0, 2'd3);
    issue(2'b10, 7'b0000011, 1'b0);
    issue(2'b10, 7'b0000000, 1'b0);
    idle_cycles(3);

    // IDLE/BUSY with bad selects are not errors.
    issue(2'b00, 7'b0000000, 1'b0);
    issue(2'b01, 7'b0000011, 1'b0);
    idle_cycles(3);

    // Errors four and five: counter stays saturated at 3.
    expect_tx(1, 1'b1, 32'h0, 2'd3);
    issue(2'b10, 7'b0110000, 1'b0);
    idle_cycles(2);
    expect_tx(1, 1'b1, 32'h0, 2'd3);
    issue(2'b11, 7'b0000000, 1'b0);
    idle_cycles(3);

    // Clear coincident with a new error leaves the count at 1.
    expect_tx(1, 1'b1, 32'h0, 2'd1);
    issue(2'b10, 7'b0000000, 1'b1);
    idle_cycles(3);

    // Plain clear.
    bus.ERR_CLR = 1'b1;
    @(posedge clk); #1;
    bus.ERR_CLR = 1'b0;
    mon_cnt = '0;
    idle_cycles(2);

    // Reset while in ERR1 returns the outputs to reset values immediately.
    mon_en = 1'b0;
    issue(2'b10, 7'b0000000, 1'b0);
    bus.HTRANS = 2'b00;
    #3;
    chk("err1_hreadyout", bus.HREADYOUT, 0);
    chk("err1_hresp", bus.HRESP, 1);
    chk("err1_err_cnt", bus.ERR_CNT, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_hreadyout", bus.HREADYOUT, 1);
    chk("rst_hresp", bus.HRESP, 0);
    chk("rst_hrdata", bus.HRDATA, 0);
    chk("rst_err_cnt", bus.ERR_CNT, 0);
    $display("reset in ERR1: hreadyout=%0d hresp=%0d err_cnt=%0d",
             bus.HREADYOUT, bus.HRESP, bus.ERR_CNT);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    mon_cnt = '0;
    mon_en  = 1'b1;
    idle_cycles(3);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
